// File: rtl/kan_pkg.sv
// rtl/kan_pkg.sv - shared constants and FIFO word type for the KAN output collector
package kan_pkg;

  localparam int KAN_NUM_PES    = 64;
  localparam int KAN_DATA_WIDTH = 16;
  localparam int KAN_PE_IDX_W   = $clog2(KAN_NUM_PES);

  // One collected result: producing PE index plus its data word
  typedef struct packed {
    logic [KAN_PE_IDX_W-1:0]   idx;
    logic [KAN_DATA_WIDTH-1:0] data;
  } kan_result_t;

endpackage

// File: rtl/kan_collect_fifo.sv
// rtl/kan_collect_fifo.sv - synchronous first-word-fall-through FIFO
module kan_collect_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;

  // Storage and pointers; storage is cleared so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kan_output_collector.sv
// rtl/kan_output_collector.sv - PE result capture, round-robin drain, frame tracking; optional stats via KAN_COLLECT_STATS_EN
module kan_output_collector
  import kan_pkg::*;
#(
  parameter int NUM_PES    = KAN_NUM_PES,
  parameter int DATA_WIDTH = KAN_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int PE_IDX_W   = KAN_PE_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic [DATA_WIDTH-1:0]         pe_data [0:NUM_PES-1],
  input  logic                          pe_valid [0:NUM_PES-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [PE_IDX_W-1:0]           out_pe_idx,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef KAN_COLLECT_STATS_EN
  ,
  output logic [31:0]                   stat_pushes,
  output logic [31:0]                   stat_stall_cycles,
  output logic [15:0]                   stat_overwrites
`endif
);

  logic [NUM_PES-1:0]    valid_vec, prev_valid, rise;
  logic [NUM_PES-1:0]    pending, pending_nxt;
  logic [NUM_PES-1:0]    delivered, delivered_nxt;
  logic [DATA_WIDTH-1:0] cap_reg [0:NUM_PES-1];
  logic [PE_IDX_W-1:0]   rr_ptr, grant_idx;
  logic                  found, grant, ovf_event, pop;
  logic                  fifo_full, fifo_empty;
  kan_result_t           push_word, head_word;
  int                    j;

  // Flatten the per-PE valid levels and detect rising edges
  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_PES; i++) valid_vec[i] = pe_valid[i];
    rise = valid_vec & ~prev_valid;
  end

  // Round-robin find-first: first pending index at or after rr_ptr, wrapping
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = 0; k < NUM_PES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_PES) j = j - NUM_PES;
      if (!found && pending[j]) begin
        found     = 1'b1;
        grant_idx = PE_IDX_W'(j);
      end
    end
    grant = found && !fifo_full;
  end

  // Next pending map; a rise on the index being drained is not an overwrite
  always_comb begin
    pending_nxt = pending;
    ovf_event   = 1'b0;
    if (grant) pending_nxt[grant_idx] = 1'b0;
    for (int i = 0; i < NUM_PES; i++) begin
      if (rise[i]) begin
        if (pending[i] && !(grant && (grant_idx == PE_IDX_W'(i)))) ovf_event = 1'b1;
        pending_nxt[i] = 1'b1;
      end
    end
  end

  // Delivered map: frame_start clears first, a coincident pop then sets its bit
  always_comb begin
    delivered_nxt = frame_start ? '0 : delivered;
    if (pop) delivered_nxt[head_word.idx] = 1'b1;
  end

  assign pop            = !fifo_empty && out_ready;
  assign push_word.idx  = grant_idx;
  assign push_word.data = cap_reg[grant_idx];

  kan_collect_fifo #(
    .WIDTH ($bits(kan_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (push_word),
    .pop       (pop),
    .head      (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = head_word.data;
  assign out_pe_idx = head_word.idx;

  // Capture registers, bitmaps, arbiter pointer and sticky frame flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= '0;
      pending    <= '0;
      delivered  <= '0;
      rr_ptr     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_PES; i++) cap_reg[i] <= '0;
    end else begin
      prev_valid <= valid_vec;
      pending    <= pending_nxt;
      delivered  <= delivered_nxt;
      for (int i = 0; i < NUM_PES; i++) begin
        if (rise[i]) cap_reg[i] <= pe_data[i];
      end
      if (grant) rr_ptr <= (grant_idx == PE_IDX_W'(NUM_PES-1)) ? '0 : grant_idx + 1'b1;
      frame_done <= (frame_start ? 1'b0 : frame_done) | (&delivered_nxt);
      overflow   <= (frame_start ? 1'b0 : overflow) | ovf_event;
    end
  end

`ifdef KAN_COLLECT_STATS_EN
  // Saturating activity counters, cleared per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pushes       <= '0;
      stat_stall_cycles <= '0;
      stat_overwrites   <= '0;
    end else if (frame_start) begin
      stat_pushes       <= '0;
      stat_stall_cycles <= '0;
      stat_overwrites   <= '0;
    end else begin
      if (grant && (stat_pushes != '1)) stat_pushes <= stat_pushes + 1'b1;
      if ((|pending) && fifo_full && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
      if (ovf_event && (stat_overwrites != '1)) stat_overwrites <= stat_overwrites + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kan_output_collector.sv
// tb/tb_kan_output_collector.sv - scoreboard bench for kan_output_collector
module tb_kan_output_collector;
  import kan_pkg::*;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] pe_data [0:N-1];
  logic          pe_valid [0:N-1];
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_pe_idx;
  logic          frame_done;
  logic          overflow;
  logic [4:0]    fifo_level;
`ifdef KAN_COLLECT_STATS_EN
  logic [31:0]   stat_pushes;
  logic [31:0]   stat_stall_cycles;
  logic [15:0]   stat_overwrites;
`endif

  int tests = 0;
  int fails = 0;
  logic [IW+DW-1:0] exp_q [$];
  logic [IW+DW-1:0] exp_w;

  kan_output_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pe_data     (pe_data),
    .pe_valid    (pe_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_pe_idx  (out_pe_idx),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
`ifdef KAN_COLLECT_STATS_EN
    ,
    .stat_pushes       (stat_pushes),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_overwrites   (stat_overwrites)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted head is compared against the oldest expected result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pop: got idx=%0d data=%h, required no output", out_pe_idx, out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({out_pe_idx, out_data} !== exp_w) begin
          fails++;
          $display("FAIL pop_order: got idx=%0d data=%h, required idx=%0d data=%h",
                   out_pe_idx, out_data, exp_w[IW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame_start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pe_valid[i] = 1'b0;
      pe_data[i]  = '0;
    end
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic expect_result(input int idx, input logic [DW-1:0] data);
    exp_q.push_back({IW'(idx), data});
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain_timeout: got %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, frame_done, overflow, fifo_level, out_data, out_pe_idx} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b done=%b ovf=%b lvl=%0d data=%h idx=%0d, required all 0",
               out_valid, frame_done, overflow, fifo_level, out_data, out_pe_idx);
    end
  endtask

  task automatic test_single();
    do_reset();
    frame_start = 1'b1;
    out_ready = 1'b1;
    tick();
    frame_start = 1'b0;
    pe_valid[5] = 1'b1;
    pe_data[5]  = 16'h1234;
    expect_result(5, 16'h1234);
    tick();
    pe_valid[5] = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_early_valid: got out_valid=%b, required 0", out_valid);
    end
    tick();
    tests++;
    if ({out_valid, out_pe_idx, out_data} !== {1'b1, 6'd5, 16'h1234}) begin
      fails++;
      $display("FAIL single_head: got valid=%b idx=%0d data=%h, required valid=1 idx=5 data=1234",
               out_valid, out_pe_idx, out_data);
    end
    drain(10, "single");
    tick();
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("FAIL single_frame_done: got %b, required 0", frame_done);
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pe_valid[i] = 1'b1;
      pe_data[i]  = DW'(i);
      expect_result(i, DW'(i));
    end
    tick();
    for (int i = 0; i < N; i++) pe_valid[i] = 1'b0;
    tick();
    tick();
    tick();
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("FAIL frame_done_early: got %b, required 0", frame_done);
    end
    drain(200, "full_frame");
    tick();
    tests++;
    if ({frame_done, overflow} !== 2'b10) begin
      fails++;
      $display("FAIL frame_complete: got done=%b ovf=%b, required done=1 ovf=0", frame_done, overflow);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("FAIL frame_start_clear: got frame_done=%b, required 0", frame_done);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pe_valid[i] = 1'b1;
      pe_data[i]  = 16'h0300 + DW'(i);
      expect_result(i, 16'h0300 + DW'(i));
    end
    tick();
    for (int i = 0; i < 20; i++) pe_valid[i] = 1'b0;
    repeat (25) tick();
    tests++;
    if ({out_valid, fifo_level} !== {1'b1, 5'd16}) begin
      fails++;
      $display("FAIL full_level: got valid=%b level=%0d, required valid=1 level=16", out_valid, fifo_level);
    end
    drain(100, "backpressure");
    tick();
    tests++;
    if ({out_valid, fifo_level, overflow} !== 7'd0) begin
      fails++;
      $display("FAIL backpressure_empty: got valid=%b level=%0d ovf=%b, required all 0",
               out_valid, fifo_level, overflow);
    end
  endtask

  task automatic test_overwrite();
    int n = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 10; i < 26; i++) begin
      pe_valid[i] = 1'b1;
      pe_data[i]  = 16'h0400 + DW'(i);
      expect_result(i, 16'h0400 + DW'(i));
    end
    tick();
    for (int i = 10; i < 26; i++) pe_valid[i] = 1'b0;
    while (fifo_level != 5'd16 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (fifo_level !== 5'd16) begin
      fails++;
      $display("FAIL overwrite_fill: got level=%0d, required 16", fifo_level);
    end
    pe_valid[3] = 1'b1;
    pe_data[3]  = 16'hAAAA;
    tick();
    pe_valid[3] = 1'b0;
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overwrite_first: got overflow=%b, required 0", overflow);
    end
    pe_valid[3] = 1'b1;
    pe_data[3]  = 16'hBBBB;
    tick();
    pe_valid[3] = 1'b0;
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overwrite_flag: got overflow=%b, required 1", overflow);
    end
    expect_result(3, 16'hBBBB);
    drain(100, "overwrite");
  endtask

  task automatic test_drain_rise();
    do_reset();
    out_ready = 1'b0;
    pe_valid[6] = 1'b1;
    pe_data[6]  = 16'h0066;
    pe_valid[7] = 1'b1;
    pe_data[7]  = 16'h0001;
    expect_result(6, 16'h0066);
    expect_result(7, 16'h0001);
    tick();
    pe_valid[6] = 1'b0;
    pe_valid[7] = 1'b0;
    tick();
    pe_valid[7] = 1'b1;
    pe_data[7]  = 16'h0002;
    expect_result(7, 16'h0002);
    tick();
    pe_valid[7] = 1'b0;
    tick();
    tick();
    tests++;
    if ({overflow, fifo_level} !== {1'b0, 5'd3}) begin
      fails++;
      $display("FAIL drain_rise_state: got ovf=%b level=%0d, required ovf=0 level=3", overflow, fifo_level);
    end
    drain(20, "drain_rise");
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 40; i < 48; i++) begin
      pe_valid[i] = 1'b1;
      pe_data[i]  = 16'h0500 + DW'(i);
    end
    tick();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, frame_done, overflow, fifo_level, out_data, out_pe_idx} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got valid=%b done=%b ovf=%b lvl=%0d data=%h idx=%0d, required all 0",
               out_valid, frame_done, overflow, fifo_level, out_data, out_pe_idx);
    end
`ifdef KAN_COLLECT_STATS_EN
    tests++;
    if ({stat_pushes, stat_stall_cycles, stat_overwrites} !== '0) begin
      fails++;
      $display("FAIL mid_reset_stats: got pushes=%0d stalls=%0d ovw=%0d, required 0",
               stat_pushes, stat_stall_cycles, stat_overwrites);
    end
`endif
    for (int i = 0; i < N; i++) pe_valid[i] = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (20) tick();
    tests++;
    if ({out_valid, fifo_level} !== 6'd0) begin
      fails++;
      $display("FAIL mid_reset_stale: got valid=%b level=%0d, required 0", out_valid, fifo_level);
    end
    pe_valid[2] = 1'b1;
    pe_data[2]  = 16'h2222;
    expect_result(2, 16'h2222);
    tick();
    pe_valid[2] = 1'b0;
    drain(10, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_frame();
    test_backpressure();
    test_overwrite();
    test_drain_rise();
    test_mid_reset();
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
